// File: rtl/clk_div_pkg.sv
// Shared constants for the core clock pulse divider: mode encodings and default widths.
package clk_div_pkg;

   localparam logic MODE_PULSE = 1'b0;
   localparam logic MODE_AUTO  = 1'b1;

   localparam int unsigned COUNTER_BITS_DEF = 32;
   localparam int unsigned PULSE_BITS_DEF   = 12;

endpackage

// File: rtl/clk_pulse_divider.sv
// Core clock generator. In pulse mode it emits N single-cycle pulses on command, and in
// auto mode it emits a free-running clock divided by 2*divider.
// Optional feature macro: CLK_PULSE_DIVIDER_BUSY_EN adds a registered `busy` output.
module clk_pulse_divider
   import clk_div_pkg::*;
#(
   parameter int unsigned COUNTER_BITS       = COUNTER_BITS_DEF,
   parameter int unsigned PULSE_CONTROL_BITS = PULSE_BITS_DEF
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write_pulse,
   input  logic                          option,
   input  logic                          out_enable,
   input  logic [COUNTER_BITS-1:0]       divider,
   input  logic [PULSE_CONTROL_BITS-1:0] pulse,
   output logic                          clk_o
`ifdef CLK_PULSE_DIVIDER_BUSY_EN
   , output logic                        busy
`endif
);

   logic                          clk_o_q, clk_o_d;
   logic [PULSE_CONTROL_BITS-1:0] remaining_q, remaining_d;
   logic [COUNTER_BITS-1:0]       div_cnt_q, div_cnt_d;
   logic [COUNTER_BITS-1:0]       half_period;
   logic                          half_done;

   // Effective half-period (divider of 0 behaves like 1) and its terminal-count compare.
   always_comb begin
      half_period = (divider == '0) ? COUNTER_BITS'(1) : divider;
      // >= rather than == so a divider lowered mid-period toggles on the very next edge.
      half_done   = (div_cnt_q >= (half_period - COUNTER_BITS'(1)));
   end

   // Next-state: a load dominates; otherwise pulse or auto rules, and clk_o falls when disabled.
   always_comb begin
      clk_o_d     = 1'b0;
      remaining_d = remaining_q;
      div_cnt_d   = div_cnt_q;
      if (write_pulse) begin
         remaining_d = pulse;
         if (option == MODE_PULSE) begin
            div_cnt_d = '0;
         end
      end else if (option == MODE_PULSE) begin
         div_cnt_d = '0;
         // A high phase always lasts one cycle, so a new pulse starts only from low.
         if (out_enable && !clk_o_q && (remaining_q != '0)) begin
            clk_o_d     = 1'b1;
            remaining_d = remaining_q - PULSE_CONTROL_BITS'(1);
         end
      end else if (out_enable) begin
         if (half_done) begin
            div_cnt_d = '0;
            clk_o_d   = ~clk_o_q;
         end else begin
            div_cnt_d = div_cnt_q + COUNTER_BITS'(1);
            clk_o_d   = clk_o_q;
         end
      end
   end

   // State registers with asynchronous reset that aborts any burst immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_o_q     <= 1'b0;
         remaining_q <= '0;
         div_cnt_q   <= '0;
      end else begin
         clk_o_q     <= clk_o_d;
         remaining_q <= remaining_d;
         div_cnt_q   <= div_cnt_d;
      end
   end

   assign clk_o = clk_o_q;

`ifdef CLK_PULSE_DIVIDER_BUSY_EN
   logic busy_q, busy_d;

   // Busy reflects the state being entered, so it drops on the edge that ends the last pulse.
   always_comb begin
      busy_d = (option == MODE_PULSE) && ((remaining_d != '0) || clk_o_d);
   end

   // Registered busy flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
`endif

endmodule

// File: tb/tb_clk_pulse_divider.sv
// Self-checking bench for clk_pulse_divider: a cycle-level behavioural model checked on every
// falling edge, plus directed scenarios with hand-computed pulse counts and patterns.
// Optional feature macro: CLK_PULSE_DIVIDER_BUSY_EN also checks the `busy` output.
module tb_clk_pulse_divider;

   logic        clk = 1'b0;
   logic        reset;
   logic        write_pulse;
   logic        option;
   logic        out_enable;
   logic [31:0] divider;
   logic [11:0] pulse;
   logic        clk_o;
`ifdef CLK_PULSE_DIVIDER_BUSY_EN
   logic        busy;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Model state in plain integers: output level, pulses still owed, auto-mode count.
   int m_clk = 0;
   int m_rem = 0;
   longint m_cnt = 0;
   int m_busy = 0;

   clk_pulse_divider #(
      .COUNTER_BITS       (32),
      .PULSE_CONTROL_BITS (12)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .write_pulse (write_pulse),
      .option      (option),
      .out_enable  (out_enable),
      .divider     (divider),
      .pulse       (pulse),
      .clk_o       (clk_o)
`ifdef CLK_PULSE_DIVIDER_BUSY_EN
      , .busy      (busy)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one step per rising clock edge, reset clears everything at once.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_clk = 0;
            m_rem = 0;
            m_cnt = 0;
            m_busy = 0;
         end else begin
            if (write_pulse) begin
               m_rem = int'(pulse);
               m_clk = 0;
               if (!option) m_cnt = 0;
            end else if (!option) begin
               m_cnt = 0;
               if (!out_enable || m_clk == 1) begin
                  m_clk = 0;
               end else if (m_rem > 0) begin
                  m_clk = 1;
                  m_rem = m_rem - 1;
               end
            end else if (!out_enable) begin
               m_clk = 0;
            end else begin
               longint h;
               h = (divider == 0) ? 1 : longint'(divider);
               if (m_cnt >= h - 1) begin
                  m_cnt = 0;
                  m_clk = 1 - m_clk;
               end else begin
                  m_cnt = m_cnt + 1;
               end
            end
            m_busy = (!option && (m_rem != 0 || m_clk == 1)) ? 1 : 0;
         end
      end
   end

   // Compare process: outputs against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check("clk_o_vs_model", int'(clk_o), m_clk);
`ifdef CLK_PULSE_DIVIDER_BUSY_EN
         check("busy_vs_model", int'(busy), m_busy);
`endif
      end
   end

   // Observe n falling-edge samples; count high samples and rising transitions.
   task automatic run_cycles(input int n, output int ones, output int rises);
      logic prev;
      ones = 0;
      rises = 0;
      prev = clk_o;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (clk_o && !prev) rises++;
         if (clk_o) ones++;
         prev = clk_o;
      end
   endtask

   // One-cycle load strobe; called and returns just after a falling edge.
   task automatic do_write(input int p);
      pulse = 12'(p);
      write_pulse = 1'b1;
      @(negedge clk);
      write_pulse = 1'b0;
   endtask

   initial begin
      int ones, rises;
      logic [7:0] pat;
      bit found;

      reset = 1'b1;
      write_pulse = 1'b0;
      option = 1'b0;
      out_enable = 1'b1;
      divider = 32'd3;
      pulse = 12'd0;
      #1;
      check("reset_clk_o", int'(clk_o), 0);
      repeat (3) @(negedge clk);
      check("reset_hold_clk_o", int'(clk_o), 0);
      reset = 1'b0;
      run_cycles(4, ones, rises);
      check("idle_no_pulses", rises, 0);

      // Three pulses: high after edges k+1, k+3, k+5 only.
      do_write(3);
      check("load_edge_low", int'(clk_o), 0);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pat = {pat[6:0], clk_o};
      end
      check("burst3_pattern", int'(pat), 8'b1010_1000);

      // Override mid-burst with 1, then cancel a burst with 0.
      do_write(10);
      run_cycles(4, ones, rises);
      check("burst10_first_two", rises, 2);
      do_write(1);
      run_cycles(10, ones, rises);
      check("override_one_more", rises, 1);
      do_write(10);
      run_cycles(1, ones, rises);
      check("burst10_restart", rises, 1);
      do_write(0);
      run_cycles(10, ones, rises);
      check("cancel_no_more", rises, 0);

      // Burst of 4 paused by out_enable for 6 cycles.
      do_write(4);
      run_cycles(4, ones, rises);
      check("pause_before", rises, 2);
      out_enable = 1'b0;
      run_cycles(6, ones, rises);
      check("pause_during_high", ones, 0);
      out_enable = 1'b1;
      run_cycles(10, ones, rises);
      check("pause_after", rises, 2);

      // Auto mode: divider 4 -> period 8, then divider 0 and 1 -> period 2.
      option = 1'b1;
      divider = 32'd4;
      run_cycles(10, ones, rises);
      run_cycles(16, ones, rises);
      check("div4_high", ones, 8);
      check("div4_rises", rises, 2);
      divider = 32'd0;
      run_cycles(10, ones, rises);
      run_cycles(16, ones, rises);
      check("div0_rises", rises, 8);
      divider = 32'd1;
      run_cycles(4, ones, rises);
      run_cycles(16, ones, rises);
      check("div1_rises", rises, 8);
      check("div1_high", ones, 8);

      // Auto mode with out_enable dropped for 5 cycles; resume phase is checked by the model.
      divider = 32'd3;
      run_cycles(13, ones, rises);
      out_enable = 1'b0;
      run_cycles(5, ones, rises);
      check("disabled_high", ones, 0);
      out_enable = 1'b1;
      run_cycles(12, ones, rises);
      check("reenabled_high", ones, 6);

      // Auto -> pulse switch with nothing loaded: output must settle low.
      option = 1'b0;
      run_cycles(2, ones, rises);
      run_cycles(6, ones, rises);
      check("switch_to_pulse_idle", ones, 0);

      // Asynchronous reset in the middle of an auto-mode high phase.
      option = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (clk_o) found = 1'b1;
      end
      check("auto_reached_high", int'(found), 1);
      #2 reset = 1'b1;
      #1 check("async_reset_clk_o", int'(clk_o), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_held_clk_o", int'(clk_o), 0);
      end
      reset = 1'b0;
      run_cycles(12, ones, rises);
      check("after_reset_high", ones, 6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
